mod_updown_counter: RTL and testbench
=====================================

// Module: mod_updown_counter
// PURPOSE
//  Parametrised synchronous up/down counter. Replaces the 4-bit ripple counter in timing-critical paths.
//  - All state changes on one clock edge, so there is no ripple skew.
//  - Adds modulus, direction, parallel load, prescaler and wrap/saturate modes.
//  - Feeds display/timer logic; wrap_out can clock-enable (never clock) a cascaded stage.
// PARAMETERS
//  WIDTH     4   counter width in bits
//  MODULUS   16  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//  PRESCALE  1   enabled cycles per count step; 1 = step on every enabled cycle
//  SATURATE  0   0 = wrap at the bounds, 1 = hold at the bound
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-low reset
//  en        in   1      count enable; also advances the prescaler
//  up        in   1      1 = count up, 0 = count down
//  clear     in   1      synchronous clear to 0
//  load      in   1      synchronous parallel load
//  load_val  in   WIDTH  value loaded when load=1
//  q         out  WIDTH  current count (registered)
//  tc        out  1      terminal count, combinational from q and up:
//                        up: q==MODULUS-1; down: q==0
//  wrap_out  out  1      registered 1-cycle pulse on the edge where q wrapped
//  sat       out  1      sticky: a step was blocked at a bound (SATURATE=1 only)
// BEHAVIOUR
//  - Reset (reset=0, asynchronous, independent of clk):
//    q=0, pre_cnt=0, wrap_out=0, sat=0. Released state holds until the first qualified edge.
//  - Per-edge priority: clear > load > count.
//    clear: q=0, pre_cnt=0, sat=0, wrap_out=0.
//    load:  q=load_val, clamped to MODULUS-1 if load_val>=MODULUS; pre_cnt=0, sat=0, wrap_out=0.
//  - Prescaler: internal pre_cnt, range 0..PRESCALE-1.
//    en=1: pre_cnt increments, wrapping to 0.
//    en=0: pre_cnt holds.
//    step = en && (pre_cnt==PRESCALE-1). PRESCALE=1 means step = en.
//  - On step, q updates on the same edge. Latency from a qualifying en cycle to a new q is 1 clock.
//    up=1,  q<MODULUS-1: q+1
//    up=1,  q==MODULUS-1: 0 and wrap_out=1 (SATURATE=0); hold and sat=1 (SATURATE=1)
//    up=0,  q>0: q-1
//    up=0,  q==0: MODULUS-1 and wrap_out=1 (SATURATE=0); hold and sat=1 (SATURATE=1)
//  - wrap_out is 0 on every edge without a wrapping step. It is never high 2 cycles in a row
//    unless the bench forces consecutive wraps with MODULUS=2 and PRESCALE=1.
//  - Direction change mid-prescale: up is sampled only on the step edge; pre_cnt is not reset.
//  - No step: q holds. Arithmetic is WIDTH bits, no carry out; compare against the MODULUS-1 constant.
//  - Clamp on load: q must never hold a value >= MODULUS, including after load.
//  - Reset mid-count, including during a wrap edge: reset wins and all outputs go to their reset values.
// TESTING
//  1 Reset: reset=0 mid-count at q=9 -> q=0, wrap_out=0, sat=0 before the next clk edge.
//  2 Wrap up, MODULUS=10, PRESCALE=1: en=1, up=1 for 12 clocks ->
//    q 1..9,0,1,2; tc=1 at q=9; wrap_out=1 exactly on the edge q=0.
//  3 Down and load, MODULUS=10: load_val=3, then down 4 steps -> q 3,2,1,0,9; wrap_out=1 on 9.
//    Then load_val=15 -> q=9 (clamped).
//  4 Prescale, PRESCALE=3: en=1 for 9 clocks -> q steps to 1,2,3 on clocks 3,6,9.
//    Drop en for 2 cycles -> pre_cnt and q hold.
//  5 Saturate, SATURATE=1, MODULUS=16: q=15, up for 3 steps -> q stays 15, sat=1, wrap_out=0.
//    Then clear -> q=0, sat=0.
//  6 Priority: clear=1, load=1, en=1 on the same edge -> q=0.
//    Then load=1, en=1, load_val=5 -> q=5, no step applied.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Synchronous up/down counter with modulus, prescaler, parallel load and wrap/saturate modes.
// Every state bit changes on the same rising edge; wrap_out is a registered clock-enable pulse.
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap_out,
    output logic             sat
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    // MODULUS itself may not fit in WIDTH bits, so every bound test uses MODULUS-1.
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_cnt;
    logic             step;
    logic             at_bound;
    logic [WIDTH-1:0] q_step;

    assign step     = en && (pre_cnt == PRE_MAX);
    assign at_bound = up ? (q == Q_MAX) : (q == '0);
    assign tc       = at_bound;

    // NOTE: always_comb assigns a default first so no path leaves q_step unassigned (no latch).
    always_comb begin
        q_step = up ? q + WIDTH'(1) : q - WIDTH'(1);
        if (at_bound) begin
            q_step = up ? '0 : Q_MAX;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q        <= '0;
            pre_cnt  <= '0;
            wrap_out <= 1'b0;
            sat      <= 1'b0;
        end else if (clear) begin
            q        <= '0;
            pre_cnt  <= '0;
            wrap_out <= 1'b0;
            sat      <= 1'b0;
        end else if (load) begin
            q        <= (load_val > Q_MAX) ? Q_MAX : load_val;
            pre_cnt  <= '0;
            wrap_out <= 1'b0;
            sat      <= 1'b0;
        end else begin
            wrap_out <= 1'b0;
            if (en) begin
                pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + PW'(1);
            end
            if (step) begin
                if (!at_bound) begin
                    q <= q_step;
                end else if (SATURATE != 0) begin
                    sat <= 1'b1;
                end else begin
                    q        <= q_step;
                    wrap_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: three instances (wrap, prescale, saturate) share one stimulus.
module tb_mod_updown_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       clear;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] q_w, q_p, q_s;
    logic       tc_w, tc_p, tc_s;
    logic       wrap_w, wrap_p, wrap_s;
    logic       sat_w, sat_p, sat_s;

    int n_tests = 0;
    int n_fail  = 0;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .q(q_w), .tc(tc_w), .wrap_out(wrap_w), .sat(sat_w)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_pre (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .q(q_p), .tc(tc_p), .wrap_out(wrap_p), .sat(sat_p)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .q(q_s), .tc(tc_s), .wrap_out(wrap_s), .sat(sat_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_dn[4];
        exp_dn = '{2, 1, 0, 9};

        reset = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
        #2;
        check("reset_q", {28'd0, q_w}, 0);
        check("reset_wrap", {31'd0, wrap_w}, 0);
        check("reset_sat", {31'd0, sat_s}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Wrap up, MODULUS=10: q 1..9,0,1,2
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("up_q[%0d]", i), {28'd0, q_w}, (i + 1) % 10);
            check($sformatf("up_tc[%0d]", i), {31'd0, tc_w}, ((i + 1) % 10 == 9) ? 1 : 0);
            check($sformatf("up_wrap[%0d]", i), {31'd0, wrap_w}, (i == 9) ? 1 : 0);
        end

        // Asynchronous reset at q=9 with a wrapping step pending
        en = 1'b0; load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0; en = 1'b1;
        check("pre_reset_q", {28'd0, q_w}, 9);
        #2 reset = 1'b0;
        #1;
        check("async_reset_q", {28'd0, q_w}, 0);
        check("async_reset_wrap", {31'd0, wrap_w}, 0);
        check("async_reset_sat", {31'd0, sat_s}, 0);
        en = 1'b0;
        #1 reset = 1'b1;

        // Down and load
        load = 1'b1; load_val = 4'd3;
        tick();
        load = 1'b0; up = 1'b0;
        check("load3_q", {28'd0, q_w}, 3);
        check("load3_tc_down", {31'd0, tc_w}, 0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("dn_q[%0d]", i), {28'd0, q_w}, exp_dn[i]);
            check($sformatf("dn_wrap[%0d]", i), {31'd0, wrap_w}, (i == 3) ? 1 : 0);
            if (i == 2) check("dn_tc_at0", {31'd0, tc_w}, 1);
        end
        en = 1'b0; load = 1'b1; load_val = 4'd15;
        tick();
        load = 1'b0;
        check("load15_clamp_q", {28'd0, q_w}, 9);
        check("load15_full_range_q", {28'd0, q_s}, 15);

        // Prescale by 3
        clear = 1'b1;
        tick();
        clear = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("pre_q[%0d]", i), {28'd0, q_p}, (i + 1) / 3);
        end
        tick();
        check("pre_mid_q", {28'd0, q_p}, 3);
        en = 1'b0;
        tick();
        tick();
        check("pre_hold_q", {28'd0, q_p}, 3);
        en = 1'b1;
        tick();
        check("pre_resume_q", {28'd0, q_p}, 3);
        tick();
        check("pre_step_q", {28'd0, q_p}, 4);
        tick();
        up = 1'b0;
        tick();
        check("pre_dirchg_hold_q", {28'd0, q_p}, 4);
        tick();
        check("pre_dirchg_step_q", {28'd0, q_p}, 3);

        // Saturate, MODULUS=16
        en = 1'b0; load = 1'b1; load_val = 4'd15;
        tick();
        load = 1'b0;
        check("sat_load_q", {28'd0, q_s}, 15);
        check("sat_load_sat", {31'd0, sat_s}, 0);
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("sat_q[%0d]", i), {28'd0, q_s}, 15);
            check($sformatf("sat_flag[%0d]", i), {31'd0, sat_s}, 1);
            check($sformatf("sat_wrap[%0d]", i), {31'd0, wrap_s}, 0);
        end
        en = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("sat_clear_q", {28'd0, q_s}, 0);
        check("sat_clear_sat", {31'd0, sat_s}, 0);
        en = 1'b1; up = 1'b0;
        tick();
        check("sat_low_q", {28'd0, q_s}, 0);
        check("sat_low_sat", {31'd0, sat_s}, 1);

        // Priority: clear > load > count
        en = 1'b0; up = 1'b1; load = 1'b1; load_val = 4'd4;
        tick();
        check("prio_setup_q", {28'd0, q_w}, 4);
        clear = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'd7;
        tick();
        check("prio_clear_q", {28'd0, q_w}, 0);
        check("prio_clear_qp", {28'd0, q_p}, 0);
        clear = 1'b0; load_val = 4'd5;
        tick();
        check("prio_load_q", {28'd0, q_w}, 5);
        check("prio_load_qp", {28'd0, q_p}, 5);
        load = 1'b0;
        tick();
        tick();
        check("prio_load_prereset_qp", {28'd0, q_p}, 5);
        tick();
        check("prio_after_qp", {28'd0, q_p}, 6);
        check("prio_after_q", {28'd0, q_w}, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
